inst_fetch_unit: RTL and testbench

- CPU-side initiator of the instruction-cache fetch interface: owns the PC, drives pc_icache_ce/icache_addr, consumes sta_icache_stall/icache_dec_inst/icache_dec_enable.
- Buffers fetched instructions in a small flushable queue and hands them to the decoder with a valid/ready handshake.
- Accepts branch redirects from the back end.

---
 rtl/cpu_defs_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 69 ++++++
 rtl/inst_fetch_unit.sv | 118 +++++++++++
 tb/tb_inst_fetch_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared types and default parameters for the instruction fetch path.
package cpu_defs;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;
    localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(4);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FULL
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Flushable synchronous FIFO holding fetched {pc, inst} entries in program order.
// Flush dominates push and pop; the head output reads as zero while empty.
module fetch_queue
    import cpu_defs::*;
#(
    parameter int  DEPTH   = 4,
    parameter type ENTRY_T = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  ENTRY_T                 push_data_i,
    output ENTRY_T                 head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int PW = $clog2(DEPTH);

    ENTRY_T        mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign count_o = count_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Overflowing pushes and underflowing pops are dropped rather than corrupting order.
    assign do_push = push_i && !flush_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !flush_i && !empty_o;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, requests from a combinational I-cache and queues
// instructions for the decoder. Define FETCH_PERF_CNT_EN to add fetch/stall perf counters.
module inst_fetch_unit #(
    parameter int                INST_W   = cpu_defs::INST_W,
    parameter int                ADDR_W   = cpu_defs::ADDR_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = cpu_defs::RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    output logic              pc_icache_ce,
    output logic [ADDR_W-1:0] icache_addr,
    input  logic              sta_icache_stall,
    input  logic [INST_W-1:0] icache_dec_inst,
    input  logic              icache_dec_enable,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              dec_ready,
    output logic              dec_valid,
    output logic [INST_W-1:0] dec_inst,
    output logic [ADDR_W-1:0] dec_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    import cpu_defs::*;

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CW-1:0]     count, count_d;
    logic              accept, pop, q_empty, q_full;
    logic              unused_redirect_lsbs;
    entry_t            push_entry, head;

    assign pc_icache_ce = (state_q == FETCH) && !q_full && !redirect_valid;
    assign icache_addr  = pc_q;
    assign accept       = pc_icache_ce && icache_dec_enable && !sta_icache_stall;
    assign dec_valid    = !q_empty && !redirect_valid;
    assign pop          = dec_valid && dec_ready;
    assign dec_inst     = head.inst;
    assign dec_pc       = head.pc;
    assign push_entry   = {pc_q, icache_dec_inst};

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    fetch_queue #(
        .DEPTH   (DEPTH),
        .ENTRY_T (entry_t)
    ) u_queue (
        .clk         (clk),
        .rst_n       (rst),
        .push_i      (accept),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .push_data_i (push_entry),
        .head_o      (head),
        .count_o     (count),
        .empty_o     (q_empty),
        .full_o      (q_full)
    );

    // Occupancy after this edge decides FULL, so fetch resumes the cycle after a pop frees a slot.
    always_comb begin
        count_d = count;
        pc_d    = pc_q;
        if (redirect_valid) begin
            count_d = '0;
            pc_d    = {redirect_pc[ADDR_W-1:2], 2'b00};
        end else begin
            count_d = count + CW'(accept) - CW'(pop);
            if (accept) pc_d = pc_q + ADDR_W'(PC_INC);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            pc_q <= pc_d;
            case (state_q)
                IDLE:    state_q <= FETCH;
                default: state_q <= (!redirect_valid && count_d == CW'(DEPTH)) ? FULL : FETCH;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    // Saturating counters; redirects deliberately leave them untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (accept && fetch_cnt_q != '1)
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (pc_icache_ce && sta_icache_stall && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios plus random traffic compared
// against a queue-based reference model of the fetch/decode behaviour.
module tb_inst_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_icache_ce;
    logic [31:0] icache_addr;
    logic        sta_icache_stall;
    logic [31:0] icache_dec_inst;
    logic        icache_dec_enable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_ready;
    logic        dec_valid;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    inst_fetch_unit #(
        .INST_W   (32),
        .ADDR_W   (32),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .pc_icache_ce      (pc_icache_ce),
        .icache_addr       (icache_addr),
        .sta_icache_stall  (sta_icache_stall),
        .icache_dec_inst   (icache_dec_inst),
        .icache_dec_enable (icache_dec_enable),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .dec_ready         (dec_ready),
        .dec_valid         (dec_valid),
        .dec_inst          (dec_inst),
        .dec_pc            (dec_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt    (perf_fetch_cnt),
        .perf_stall_cnt    (perf_stall_cnt)
`endif
    );

    function automatic logic [31:0] instOf(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Combinational cache: the instruction is a fixed hash of the requested address.
    assign icache_dec_inst = instOf(icache_addr);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mPc;
    bit          mStarted;
    logic [31:0] mFetch, mStall;
    int          compared = 0;
    int          mismatched = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge: drive, check against the model, then advance one clock.
    task automatic applyStimulus(input logic stall, input logic en, input logic redir,
                                 input logic [31:0] rpc, input logic ready);
        bit          expCe, expValid;
        logic [31:0] expPc, expInst;
        sta_icache_stall  = stall;
        icache_dec_enable = en;
        redirect_valid    = redir;
        redirect_pc       = rpc;
        dec_ready         = ready;
        #1;
        expCe    = mStarted && (mq.size() < DEPTH) && !redir;
        expValid = (mq.size() != 0) && !redir;
        expPc    = (mq.size() != 0) ? mq[0].pc : 32'h0;
        expInst  = (mq.size() != 0) ? mq[0].inst : 32'h0;
        checkOutput("ce", 64'(pc_icache_ce), 64'(expCe));
        checkOutput("icache_addr", 64'(icache_addr), 64'(mPc));
        checkOutput("dec_valid", 64'(dec_valid), 64'(expValid));
        checkOutput("dec_pc", 64'(dec_pc), 64'(expPc));
        checkOutput("dec_inst", 64'(dec_inst), 64'(expInst));
`ifdef FETCH_PERF_CNT_EN
        checkOutput("perf_fetch", 64'(perf_fetch_cnt), 64'(mFetch));
        checkOutput("perf_stall", 64'(perf_stall_cnt), 64'(mStall));
`endif
        @(posedge clk);
        mStarted = 1'b1;
        if (expCe && stall && mStall != 32'hFFFF_FFFF) mStall++;
        if (redir) begin
            mq.delete();
            mPc = rpc & ~32'h3;
        end else begin
            if (expValid && ready) void'(mq.pop_front());
            if (expCe && en && !stall) begin
                mq.push_back('{mPc, instOf(mPc)});
                if (mFetch != 32'hFFFF_FFFF) mFetch++;
                mPc = mPc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b0;
        #1;
        mq.delete();
        mPc      = 32'h0;
        mStarted = 1'b0;
        mFetch   = 32'h0;
        mStall   = 32'h0;
        checkOutput("rst_ce", 64'(pc_icache_ce), 64'h0);
        checkOutput("rst_addr", 64'(icache_addr), 64'h0);
        checkOutput("rst_dec_valid", 64'(dec_valid), 64'h0);
        checkOutput("rst_dec_inst", 64'(dec_inst), 64'h0);
        checkOutput("rst_dec_pc", 64'(dec_pc), 64'h0);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("rst_perf_fetch", 64'(perf_fetch_cnt), 64'h0);
        checkOutput("rst_perf_stall", 64'(perf_stall_cnt), 64'h0);
`endif
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst               = 1'b0;
        sta_icache_stall  = 1'b0;
        icache_dec_enable = 1'b0;
        redirect_valid    = 1'b0;
        redirect_pc       = 32'h0;
        dec_ready         = 1'b0;

        // Streaming: one instruction per cycle, first decode two cycles after release.
        doReset();
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

        // Stall three cycles while the address sits at 0x8.
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("stall_addr", 64'(icache_addr), 64'h8);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

        // Fill the queue with the decoder blocked, then release a single entry.
        doReset();
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("refill_addr", 64'(icache_addr), 64'h10);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

        // Redirect to an unaligned target with three entries queued.
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h103, 1'b1);
        checkOutput("redir_addr", 64'(icache_addr), 64'h100);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

        // PC wrap at the top of the address space, plus back-to-back redirects.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h4000_0000, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("wrap_addr", 64'(icache_addr), 64'h0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 99) < 30,
                          $urandom_range(0, 99) < 80,
                          $urandom_range(0, 99) < 5,
                          $urandom,
                          $urandom_range(0, 99) < 60);
        end

        // Asynchronous reset asserted in the middle of a stall.
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        #3;
        doReset();
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
